// File: rtl/display_stream_timing.sv
// rtl/display_stream_timing.sv - buffered pixel stream to raster timing with hsync/vsync/de
module display_stream_timing #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_de,
    output logic              disp_hsync,
    output logic              disp_vsync,
    output logic              frame_done,
    output logic              underflow,
    output logic              sync_err,
    input  logic              clr_status
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
    localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
    localparam int AW      = $clog2(FIFO_DEPTH);

    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic [DATA_W:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              ready_en;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              active;
    logic              hsync;
    logic              vsync;
    logic              h_last;
    logic              v_last;
    logic              frame_start;
    logic              head_sof;
    logic [DATA_W-1:0] head_data;

    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    // ready_en keeps in_ready low until the first clock after reset release
    assign in_ready = ready_en && !full;
    assign push     = in_valid && in_ready;

    assign active = enable && (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    assign hsync  = enable && (int'(h_cnt) >= H_ACTIVE + H_FP)
                           && (int'(h_cnt) <  H_ACTIVE + H_FP + H_SYNC);
    assign vsync  = enable && (int'(v_cnt) >= V_ACTIVE + V_FP)
                           && (int'(v_cnt) <  V_ACTIVE + V_FP + V_SYNC);
    assign h_last      = (int'(h_cnt) == H_TOTAL - 1);
    assign v_last      = (int'(v_cnt) == V_TOTAL - 1);
    assign frame_start = (h_cnt == '0) && (v_cnt == '0);

    assign pop                   = active && !empty;
    assign {head_sof, head_data} = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_sof, in_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (!enable) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    // Outputs decode the current counter state one clock late, keeping de/sync/data aligned
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            disp_data  <= '0;
            disp_de    <= 1'b0;
            disp_hsync <= 1'b0;
            disp_vsync <= 1'b0;
            frame_done <= 1'b0;
            underflow  <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            disp_data  <= pop ? head_data : '0;
            disp_de    <= active;
            disp_hsync <= hsync;
            disp_vsync <= vsync;
            frame_done <= enable && h_last && v_last;
            if (active && empty) begin
                underflow <= 1'b1;
            end else if (clr_status) begin
                underflow <= 1'b0;
            end
            if (pop && (head_sof != frame_start)) begin
                sync_err <= 1'b1;
            end else if (clr_status) begin
                sync_err <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_display_stream_timing.sv
// tb/tb_display_stream_timing.sv - directed and random checks of display_stream_timing against a raster model
module tb_display_stream_timing;
    localparam int DW = 32, DEPTH = 16;
    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 2, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    logic          clk, reset_n, enable, in_sof, in_valid, clr_status;
    logic [DW-1:0] in_data, disp_data;
    logic          in_ready, disp_de, disp_hsync, disp_vsync, frame_done, underflow, sync_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [DW:0]   q[$];
    int            t;
    bit            rdy;
    logic          e_de, e_hs, e_vs, e_fd, e_uf, e_se;
    logic [DW-1:0] e_data;

    display_stream_timing #(
        .DATA_W(DW), .FIFO_DEPTH(DEPTH),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .in_data(in_data), .in_sof(in_sof), .in_valid(in_valid), .in_ready(in_ready),
        .disp_data(disp_data), .disp_de(disp_de), .disp_hsync(disp_hsync),
        .disp_vsync(disp_vsync), .frame_done(frame_done), .underflow(underflow),
        .sync_err(sync_err), .clr_status(clr_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic check_outs();
        check("disp_de",    DW'(disp_de),    DW'(e_de));
        check("disp_hsync", DW'(disp_hsync), DW'(e_hs));
        check("disp_vsync", DW'(disp_vsync), DW'(e_vs));
        check("frame_done", DW'(frame_done), DW'(e_fd));
        check("underflow",  DW'(underflow),  DW'(e_uf));
        check("sync_err",   DW'(sync_err),   DW'(e_se));
        check("disp_data",  disp_data,       e_data);
    endtask

    task automatic model_reset();
        q.delete();
        t = 0; rdy = 0;
        e_de = 0; e_hs = 0; e_vs = 0; e_fd = 0; e_uf = 0; e_se = 0; e_data = '0;
    endtask

    // Raster position is derived from the number of enabled cycles since enable rose
    task automatic step(input bit en, input bit v, input bit s, input logic [DW-1:0] d, input bit clr);
        bit          acc, act, emp, pop, set_uf, set_se;
        int          h, vv;
        logic [DW:0] w;
        enable = en; in_valid = v; in_sof = s; in_data = d; clr_status = clr;
        acc = v && rdy && (q.size() < DEPTH);
        check("in_ready", DW'(in_ready), DW'(rdy && (q.size() < DEPTH)));
        emp = (q.size() == 0);
        act = 0; pop = 0; set_uf = 0; set_se = 0; w = '0;
        if (en) begin
            h   = t % HT;
            vv  = (t / HT) % VT;
            act = (h < HA) && (vv < VA);
            pop = act && !emp;
            if (pop) w = q.pop_front();
            e_de   = act;
            e_hs   = (h >= HA + HF) && (h < HA + HF + HS);
            e_vs   = (vv >= VA + VF) && (vv < VA + VF + VS);
            e_fd   = (h == HT - 1) && (vv == VT - 1);
            e_data = pop ? w[DW-1:0] : '0;
            set_uf = act && emp;
            set_se = pop && (w[DW] != ((h == 0) && (vv == 0)));
            t++;
        end else begin
            e_de = 0; e_hs = 0; e_vs = 0; e_fd = 0; e_data = '0;
            t = 0;
        end
        if (acc) q.push_back({s, d});
        e_uf = set_uf ? 1'b1 : (clr ? 1'b0 : e_uf);
        e_se = set_se ? 1'b1 : (clr ? 1'b0 : e_se);
        rdy = 1;
        @(posedge clk);
        #1;
        check_outs();
    endtask

    initial begin
        reset_n = 0; enable = 0; in_valid = 0; in_sof = 0; in_data = '0; clr_status = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs();
        check("in_ready_rst", DW'(in_ready), '0);
        reset_n = 1;

        // ordered frame: 1..8 with sof on the first word
        for (int i = 1; i <= 8; i++) step(0, 1, i == 1, DW'(i), 0);
        repeat (HT * VT) step(1, 0, 0, '0, 0);

        // underflow: only three words for a frame, then clear
        for (int i = 1; i <= 3; i++) step(0, 1, i == 1, DW'(i + 16), 0);
        repeat (HT * VT) step(1, 0, 0, '0, 0);
        step(0, 0, 0, '0, 1);

        // backpressure: 20 offered while idle, then drain over two frames
        for (int i = 0; i < 20; i++) step(0, 1, (i % 8) == 0, $urandom, 0);
        repeat (2 * HT * VT) step(1, 0, 0, '0, 0);

        // misplaced sof on the second word; flag survives later frames
        for (int i = 0; i < 8; i++) step(0, 1, i == 1, $urandom, 0);
        repeat (2 * HT * VT) step(1, 0, 0, '0, 0);
        step(0, 0, 0, '0, 1);

        // random traffic with occasional clear and enable drops
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 39) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 15) == 0);

        // reset in the middle of the active region
        step(0, 0, 0, '0, 1);
        for (int i = 0; i < 4; i++) step(0, 1, i == 0, $urandom, 0);
        repeat (2) step(1, 0, 0, '0, 0);
        reset_n = 0;
        #1;
        model_reset();
        check_outs();
        check("in_ready_midrst", DW'(in_ready), '0);
        @(posedge clk);
        #1;
        check_outs();
        reset_n = 1;
        step(0, 0, 0, '0, 0);
        step(0, 0, 0, '0, 0);
        repeat (HT * VT) step(1, $urandom_range(0, 1) == 1, 0, $urandom, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
